// File: rtl/sdram_port_arbiter.sv
// Arbitrates the SDRAM controller user port between the QSPI read path and the USB write path.
// Define ARB_STATS_EN to add saturating grant/starvation statistics outputs.
//
// state  | meaning
// IDLE   | nothing presented to the controller; grant decision is made here
// CMD_RD | read command held on m_* until the controller accepts it
// CMD_WR | write command held on m_*; may chain back-to-back write beats

module sdram_port_arbiter #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 16,
    parameter int RD_BEATS   = 2,
    parameter int MAX_OUT    = 2,
    parameter int STARVE_MAX = 4,
    parameter int WR_BURST   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sdram_init_done,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_avalid,
    output logic              rd_aready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_we,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rvalid,
    output logic              m_rready
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       rd_grant_cnt,
    output logic [15:0]       wr_grant_cnt,
    output logic [15:0]       starve_evt_cnt
`endif
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int ST_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int BU_W  = $clog2(WR_BURST + 1);
    localparam int BT_W  = (RD_BEATS > 1) ? $clog2(RD_BEATS) : 1;

    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);
    localparam logic [ST_W-1:0]  ST_MAX  = ST_W'(STARVE_MAX);
    localparam logic [BU_W-1:0]  BU_MAX  = BU_W'(WR_BURST);
    localparam logic [BT_W-1:0]  BT_LAST = BT_W'(RD_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD_RD = 2'd1,
        CMD_WR = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              m_we_q, m_we_d;
    logic              m_valid_q, m_valid_d;
    logic [OUT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [ST_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic [BU_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [BT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic rd_ok;
    logic write_force;
    logic grant_rd;
    logic retire;

    assign rd_data  = m_rdata;
    assign rd_valid = m_rvalid;
    assign m_rready = rd_ready;

    assign m_addr  = m_addr_q;
    assign m_we    = m_we_q;
    assign m_wdata = m_wdata_q;
    assign m_valid = m_valid_q;

    assign rd_ok       = rd_avalid && (out_cnt_q < OUT_MAX);
    assign write_force = wr_valid && (starve_cnt_q == ST_MAX);

    always_comb begin
        state_d      = state_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_we_d       = m_we_q;
        m_valid_d    = m_valid_q;
        starve_cnt_d = starve_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        out_cnt_d    = out_cnt_q;
        rd_aready    = 1'b0;
        wr_ready     = 1'b0;
        grant_rd     = 1'b0;
        retire       = 1'b0;

        // Beats that arrive with nothing outstanding are not attributed to any command.
        if (m_rvalid && rd_ready && (out_cnt_q != '0)) begin
            if (beat_cnt_q == BT_LAST) begin
                beat_cnt_d = '0;
                retire     = 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (sdram_init_done) begin
                    if (rd_ok && !write_force) begin
                        rd_aready = 1'b1;
                        grant_rd  = 1'b1;
                        m_addr_d  = rd_addr;
                        m_we_d    = 1'b0;
                        m_valid_d = 1'b1;
                        state_d   = CMD_RD;
                        if (!wr_valid) begin
                            starve_cnt_d = '0;
                        end else if (starve_cnt_q != ST_MAX) begin
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                    end else if (wr_valid) begin
                        wr_ready     = 1'b1;
                        m_addr_d     = wr_addr;
                        m_wdata_d    = wr_data;
                        m_we_d       = 1'b1;
                        m_valid_d    = 1'b1;
                        starve_cnt_d = '0;
                        burst_cnt_d  = BU_W'(1);
                        state_d      = CMD_WR;
                    end
                end
            end
            CMD_RD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            CMD_WR: begin
                if (m_ready) begin
                    // Chaining is a new grant, so it also respects the init gate.
                    if (sdram_init_done && wr_valid && (burst_cnt_q < BU_MAX) && !rd_ok) begin
                        wr_ready    = 1'b1;
                        m_addr_d    = wr_addr;
                        m_wdata_d   = wr_data;
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end else begin
                        m_valid_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                m_valid_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        if (grant_rd && !retire && (out_cnt_q != OUT_MAX)) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (retire && !grant_rd) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_we_q       <= 1'b0;
            m_valid_q    <= 1'b0;
            out_cnt_q    <= '0;
            starve_cnt_q <= '0;
            burst_cnt_q  <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_we_q       <= m_we_d;
            m_valid_q    <= m_valid_d;
            out_cnt_q    <= out_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] rd_grant_cnt_q, rd_grant_cnt_d;
    logic [15:0] wr_grant_cnt_q, wr_grant_cnt_d;
    logic [15:0] starve_evt_cnt_q, starve_evt_cnt_d;

    always_comb begin
        rd_grant_cnt_d   = rd_grant_cnt_q;
        wr_grant_cnt_d   = wr_grant_cnt_q;
        starve_evt_cnt_d = starve_evt_cnt_q;
        if (rd_aready && (rd_grant_cnt_q != 16'hFFFF)) begin
            rd_grant_cnt_d = rd_grant_cnt_q + 16'd1;
        end
        if (wr_ready && (wr_grant_cnt_q != 16'hFFFF)) begin
            wr_grant_cnt_d = wr_grant_cnt_q + 16'd1;
        end
        if ((state_q == IDLE) && wr_ready && write_force && (starve_evt_cnt_q != 16'hFFFF)) begin
            starve_evt_cnt_d = starve_evt_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_grant_cnt_q   <= '0;
            wr_grant_cnt_q   <= '0;
            starve_evt_cnt_q <= '0;
        end else begin
            rd_grant_cnt_q   <= rd_grant_cnt_d;
            wr_grant_cnt_q   <= wr_grant_cnt_d;
            starve_evt_cnt_q <= starve_evt_cnt_d;
        end
    end

    assign rd_grant_cnt   = rd_grant_cnt_q;
    assign wr_grant_cnt   = wr_grant_cnt_q;
    assign starve_evt_cnt = starve_evt_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios followed by a randomized run
// checked by a command scoreboard, an owed-beats model and a starvation-run model.

module tb_sdram_port_arbiter;

    localparam int ADDR_W     = 22;
    localparam int DATA_W     = 16;
    localparam int RD_BEATS   = 2;
    localparam int MAX_OUT    = 2;
    localparam int STARVE_MAX = 4;
    localparam int WR_BURST   = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              sdram_init_done = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_avalid = 1'b0;
    logic              rd_aready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [DATA_W-1:0] m_wdata;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_rdata = '0;
    logic              m_rvalid = 1'b0;
    logic              m_rready;
`ifdef ARB_STATS_EN
    logic [15:0]       rd_grant_cnt;
    logic [15:0]       wr_grant_cnt;
    logic [15:0]       starve_evt_cnt;
`endif

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_BEATS(RD_BEATS),
        .MAX_OUT(MAX_OUT), .STARVE_MAX(STARVE_MAX), .WR_BURST(WR_BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done),
        .rd_addr(rd_addr), .rd_avalid(rd_avalid), .rd_aready(rd_aready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_valid(m_valid), .m_ready(m_ready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready)
`ifdef ARB_STATS_EN
        , .rd_grant_cnt(rd_grant_cnt), .wr_grant_cnt(wr_grant_cnt), .starve_evt_cnt(starve_evt_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    int   n_checks = 0;
    int   n_errors = 0;
    cmd_t exp_q[$];
    byte  grant_log[$];
    int   owed = 0;
    int   run_rd = 0;
    cmd_t mon_c;

    logic [ADDR_W-1:0] b_addr[10];
    logic [DATA_W-1:0] b_data[10];
    logic              exp_mv[14];
    int                idx;
    int                rem;
    int                pos;
    logic              hs_r;
    logic              hs_w;
    byte               exp_g;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        rd_avalid = 1'b0; wr_valid = 1'b0; m_ready = 1'b0;
        m_rvalid = 1'b0; rd_ready = 1'b0; sdram_init_done = 1'b0;
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    // Transaction-level monitor; values seen at the falling edge are those the next rising edge acts on.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            owed   = 0;
            run_rd = 0;
        end else begin
            check("pass_rd_data", rd_data, m_rdata);
            check("pass_rd_valid", rd_valid, m_rvalid);
            check("pass_m_rready", m_rready, rd_ready);
            check("ready_exclusive", rd_aready & wr_ready, 1'b0);
            if (rd_aready) begin
                check("rd_limit", ((owed + RD_BEATS - 1) / RD_BEATS) < MAX_OUT, 1'b1);
            end
            if (m_valid && m_ready) begin
                check("cmd_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    mon_c = exp_q.pop_front();
                    check("cmd_we", m_we, mon_c.we);
                    check("cmd_addr", m_addr, mon_c.addr);
                    if (mon_c.we) check("cmd_wdata", m_wdata, mon_c.data);
                end
            end
            if (m_rvalid && rd_ready && owed > 0) owed--;
            if (rd_avalid && rd_aready) begin
                exp_q.push_back('{1'b0, rd_addr, '0});
                owed += RD_BEATS;
                grant_log.push_back("R");
                run_rd = wr_valid ? run_rd + 1 : 0;
                check("starve_guard", run_rd <= STARVE_MAX, 1'b1);
            end
            if (wr_valid && wr_ready) begin
                exp_q.push_back('{1'b1, wr_addr, wr_data});
                grant_log.push_back("W");
                run_rd = 0;
            end
        end
    end

    initial begin
        // Reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_we", m_we, 1'b0);
        check("rst_m_addr", m_addr, '0);
        check("rst_m_wdata", m_wdata, '0);
        check("rst_rd_aready", rd_aready, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b0);
`ifdef ARB_STATS_EN
        check("rst_rd_grant_cnt", rd_grant_cnt, 16'd0);
`endif
        cyc();
        rst_n = 1'b1;
        cyc();

        // Init gate, then read wins over write
        rd_avalid = 1'b1; rd_addr = 22'h12345;
        wr_valid = 1'b1; wr_addr = 22'h0ABCD; wr_data = 16'h5555;
        repeat (20) begin
            cyc();
            #1;
            check("gate_rd_aready", rd_aready, 1'b0);
            check("gate_wr_ready", wr_ready, 1'b0);
            check("gate_m_valid", m_valid, 1'b0);
        end
        cyc();
        sdram_init_done = 1'b1;
        #1;
        check("init_rd_aready", rd_aready, 1'b1);
        check("init_wr_ready", wr_ready, 1'b0);
        check("init_m_valid_pre", m_valid, 1'b0);
        cyc();
        #1;
        check("init_m_valid", m_valid, 1'b1);
        check("init_m_addr", m_addr, 22'h12345);
        check("init_m_we", m_we, 1'b0);
        check("init_rd_aready_drop", rd_aready, 1'b0);
        rd_avalid = 1'b0; wr_valid = 1'b0; m_ready = 1'b1;
        cyc();
        #1;
        check("rd_cmd_done", m_valid, 1'b0);
        m_ready = 1'b0;
        m_rvalid = 1'b1; rd_ready = 1'b1; m_rdata = 16'hBEEF;
        #1;
        check("pt_rd_data", rd_data, 16'hBEEF);
        check("pt_rd_valid", rd_valid, 1'b1);
        check("pt_m_rready", m_rready, 1'b1);
        cyc();
        cyc();
        m_rvalid = 1'b0; rd_ready = 1'b0;

        // Priority and starvation guard
        reset_dut();
        sdram_init_done = 1'b1; rd_avalid = 1'b1; rd_addr = 22'h00100;
        wr_valid = 1'b1; wr_addr = 22'h00200; wr_data = 16'h1234;
        m_ready = 1'b1; m_rvalid = 1'b1; rd_ready = 1'b1;
        grant_log.delete();
        for (int i = 0; i < 100 && grant_log.size() < STARVE_MAX + 1; i++) cyc();
`ifdef ARB_STATS_EN
        check("starve_evt_after_first_w", starve_evt_cnt, 16'd1);
`endif
        for (int i = 0; i < 200 && grant_log.size() < 10; i++) cyc();
        check("prio_grant_count", grant_log.size() >= 10, 1'b1);
        for (int k = 0; k < 10 && k < grant_log.size(); k++) begin
            exp_g = ((k % (STARVE_MAX + 1)) == STARVE_MAX) ? "W" : "R";
            check($sformatf("prio_order_%0d", k), grant_log[k], exp_g);
        end

        // Outstanding read limit
        reset_dut();
        sdram_init_done = 1'b1; rd_avalid = 1'b1; rd_addr = 22'h00300; m_ready = 1'b1;
        grant_log.delete();
        repeat (12) cyc();
        check("out_grants", grant_log.size(), MAX_OUT);
        #1;
        check("out_rd_aready_blocked", rd_aready, 1'b0);
        m_rvalid = 1'b1; rd_ready = 1'b1;
        repeat (RD_BEATS) cyc();
        m_rvalid = 1'b0; rd_ready = 1'b0;
        for (int i = 0; i < 10 && grant_log.size() < MAX_OUT + 1; i++) cyc();
        check("out_third_grant", grant_log.size(), MAX_OUT + 1);

        // Write burst of 10 beats
        reset_dut();
        sdram_init_done = 1'b1; m_ready = 1'b1; rd_avalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            b_addr[i] = ADDR_W'($urandom);
            b_data[i] = DATA_W'($urandom);
        end
        rem = 10; pos = 0;
        for (int i = 0; i < 14; i++) exp_mv[i] = 1'b0;
        while (rem > 0) begin
            pos++;
            for (int j = 0; j < WR_BURST && rem > 0; j++) begin
                exp_mv[pos] = 1'b1;
                pos++;
                rem--;
            end
        end
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            wr_valid = (idx < 10);
            if (idx < 10) begin
                wr_addr = b_addr[idx];
                wr_data = b_data[idx];
            end
            #1;
            check($sformatf("burst_m_valid_%0d", c), m_valid, exp_mv[c]);
            if (m_valid) check($sformatf("burst_m_we_%0d", c), m_we, 1'b1);
            hs_w = wr_valid && wr_ready;
            cyc();
            if (hs_w) idx++;
        end
        check("burst_all_accepted", idx, 10);
        wr_valid = 1'b0;

        // Read arriving mid-burst ends the burst after the current beat
        reset_dut();
        sdram_init_done = 1'b1; m_ready = 1'b1;
        wr_valid = 1'b1; wr_addr = 22'h01000; wr_data = 16'h0F0F;
        cyc(); cyc(); cyc();
        rd_avalid = 1'b1; rd_addr = 22'h2AAAA;
        #1;
        check("mid_m_valid", m_valid, 1'b1);
        check("mid_wr_ready", wr_ready, 1'b0);
        check("mid_rd_aready", rd_aready, 1'b0);
        cyc();
        #1;
        check("mid_end_m_valid", m_valid, 1'b0);
        check("mid_rd_granted", rd_aready, 1'b1);
        cyc();
        #1;
        check("mid_rd_m_we", m_we, 1'b0);
        check("mid_rd_m_addr", m_addr, 22'h2AAAA);
        rd_avalid = 1'b0; wr_valid = 1'b0;

        // Backpressure on a write
        reset_dut();
        sdram_init_done = 1'b1; m_ready = 1'b0;
        wr_valid = 1'b1; wr_addr = 22'h3FFFFF; wr_data = 16'hA5A5;
        #1;
        check("bp_grant", wr_ready, 1'b1);
        cyc();
        wr_addr = 22'h000001; wr_data = 16'h1111;
        repeat (5) begin
            #1;
            check("bp_m_addr", m_addr, 22'h3FFFFF);
            check("bp_m_wdata", m_wdata, 16'hA5A5);
            check("bp_m_valid", m_valid, 1'b1);
            check("bp_wr_ready", wr_ready, 1'b0);
            cyc();
        end
        m_ready = 1'b1;
        #1;
        check("bp_next_accept", wr_ready, 1'b1);
        cyc();
        m_ready = 1'b0;
        #1;
        check("bp_next_m_addr", m_addr, 22'h000001);
        check("bp_next_m_wdata", m_wdata, 16'h1111);
        check("bp_next_m_valid", m_valid, 1'b1);

        // Asynchronous reset while a write is held
        rst_n = 1'b0;
        #1;
        check("arst_m_valid", m_valid, 1'b0);
        check("arst_m_addr", m_addr, '0);
        check("arst_m_wdata", m_wdata, '0);
        check("arst_m_we", m_we, 1'b0);
`ifdef ARB_STATS_EN
        check("arst_wr_grant_cnt", wr_grant_cnt, 16'd0);
        check("arst_starve_evt_cnt", starve_evt_cnt, 16'd0);
`endif
        cyc();
        rst_n = 1'b1;
        #1;
        check("arst_idle_grant", wr_ready, 1'b1);
        wr_valid = 1'b0;
        cyc();

        // Randomized traffic against the monitor models
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            if (!rd_avalid) begin
                rd_avalid = ($urandom_range(0, 2) == 0);
                rd_addr = ADDR_W'($urandom);
            end
            if (!wr_valid) begin
                wr_valid = ($urandom_range(0, 2) == 0);
                wr_addr = ADDR_W'($urandom);
                wr_data = DATA_W'($urandom);
            end
            m_ready = ($urandom_range(0, 3) != 0);
            m_rvalid = ($urandom_range(0, 2) == 0);
            m_rdata = DATA_W'($urandom);
            rd_ready = ($urandom_range(0, 3) != 0);
            sdram_init_done = ($urandom_range(0, 15) != 0);
            #1;
            hs_r = rd_avalid && rd_aready;
            hs_w = wr_valid && wr_ready;
            cyc();
            if (hs_r) rd_avalid = 1'b0;
            if (hs_w) wr_valid = 1'b0;
        end
        rd_avalid = 1'b0; wr_valid = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
